wasm_instr_loader: RTL and testbench
====================================

WASM_INSTR_LOADER -- requirements
Module: wasm_instr_loader

Interface
REQ-001 Parameter WORD_BYTES, default 8, bytes per instruction word; output data width is 8*WORD_BYTES.
REQ-002 Parameter ADDR_W, default 15, instruction-memory word address width.
REQ-003 Parameter LEN_W, default 32, width of the byte-length field.
REQ-004 i_clk  input  1  sole clock, rising edge.
REQ-005 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_start  input  1  single-cycle pulse that begins a load.
REQ-007 i_len_bytes  input  LEN_W  program length in bytes, sampled on i_start.
REQ-008 i_byte_vld  input  1  source byte valid.
REQ-009 i_byte  input  8  source byte.
REQ-010 o_byte_rdy  output  1  loader accepts a byte this cycle.
REQ-011 o_instr_mem_wr_vld  output  1  word write request.
REQ-012 o_instr_mem_wr_addr  output  ADDR_W  word address.
REQ-013 o_instr_mem_wr_data  output  8*WORD_BYTES  packed word.
REQ-014 i_instr_mem_wr_rdy  input  1  instruction memory accepts the write.
REQ-015 o_instr_mem_wr_finish  output  1  load complete, level.
REQ-016 o_busy  output  1  high in PACK or WRITE.
REQ-017 o_err  output  1  length exceeds memory capacity.
REQ-018 o_checksum  output  32  running byte sum (see Configuration).

Function
REQ-019 The block SHALL implement states IDLE, PACK, WRITE, DONE.
REQ-020 IDLE: on i_start, latch i_len_bytes, clear byte/word counters and o_err, drop finish; next state PACK, or DONE if length is 0, or IDLE with o_err=1 if ceil(len/WORD_BYTES) > 2^ADDR_W.
REQ-021 o_byte_rdy SHALL be 1 only in PACK; a byte transfers when i_byte_vld && o_byte_rdy.
REQ-022 Packing SHALL be little-endian: the k-th byte of a word occupies bits [8k+7:8k].
REQ-023 PACK SHALL go to WRITE the cycle after the WORD_BYTES-th byte of a word or the final byte of the program is accepted.
REQ-024 A final partial word SHALL have unfilled byte lanes set to 8'h00.
REQ-025 WRITE: o_instr_mem_wr_vld=1 with addr and data held stable until i_instr_mem_wr_rdy=1; that cycle completes the write.
REQ-026 After a completed write, address SHALL increment by 1; next state PACK if bytes remain, else DONE.
REQ-027 First word SHALL be written to address 0; addresses never wrap (guaranteed by REQ-020).
REQ-028 DONE: o_instr_mem_wr_finish=1, held until the next i_start; i_start in DONE behaves as in IDLE.
REQ-029 i_start while o_busy=1 SHALL be ignored.
REQ-030 Bytes offered in IDLE, WRITE or DONE SHALL NOT be consumed.

Reset
REQ-031 While i_rst_n=0, the block SHALL enter IDLE and drive all outputs, counters, data and checksum to 0, including mid-load; no partial write is issued after release.

Configuration
REQ-032 Macro WASM_LOADER_CHECKSUM_EN defined: o_checksum SHALL accumulate the 32-bit modulo-2^32 sum of every accepted byte since the last i_start, updating the cycle after acceptance; padding bytes excluded.
REQ-033 Macro undefined: no accumulator is built and o_checksum SHALL be constant 0.

Verification
REQ-034 len=16, bytes 0x00..0x0F, rdy always 1 -> two writes: addr 0 data 0x0706050403020100, addr 1 data 0x0F0E0D0C0B0A0908; then finish=1.
REQ-035 len=10, bytes 0x01..0x0A -> addr 1 data 0x0000_0000_0000_0A09; with WASM_LOADER_CHECKSUM_EN checksum=55, without it 0.
REQ-036 wr_rdy low 5 cycles during WRITE -> vld, addr, data unchanged for all 5 cycles; o_byte_rdy=0 throughout.
REQ-037 len=0 -> no write, finish=1 the cycle after i_start; ADDR_W=2, len=33 -> o_err=1, state IDLE, no write.
REQ-038 Reset asserted after 3 bytes of a word -> all outputs 0; new i_start with len=8 writes exactly one word at addr 0 from fresh bytes.
REQ-039 WORD_BYTES=4: len=8, bytes 0x11..0x18 -> addr 0 0x14131211, addr 1 0x18171615.

Source files
------------

// File: rtl/wasm_instr_loader.sv
// Streams program bytes into little-endian instruction words and writes them to instruction memory.
// Optional WASM_LOADER_CHECKSUM_EN builds a 32-bit running byte sum on o_checksum.
module wasm_instr_loader #(
  parameter int unsigned WORD_BYTES = 8,
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned LEN_W      = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [LEN_W-1:0]        i_len_bytes,
  input  logic                    i_byte_vld,
  input  logic [7:0]              i_byte,
  output logic                    o_byte_rdy,
  output logic                    o_instr_mem_wr_vld,
  output logic [ADDR_W-1:0]       o_instr_mem_wr_addr,
  output logic [8*WORD_BYTES-1:0] o_instr_mem_wr_data,
  input  logic                    i_instr_mem_wr_rdy,
  output logic                    o_instr_mem_wr_finish,
  output logic                    o_busy,
  output logic                    o_err,
  output logic [31:0]             o_checksum
);

  localparam int unsigned LANE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WORD_BYTES - 1);
  // ceil(len/WORD_BYTES) > 2^ADDR_W is equivalent to len > WORD_BYTES * 2^ADDR_W
  localparam logic [63:0] CAP_BYTES = 64'(WORD_BYTES) << ADDR_W;

  typedef enum logic [1:0] {IDLE, PACK, WRITE, DONE} state_t;

  state_t                  state_q, state_d;
  logic [LEN_W-1:0]        len_q, cnt_q;
  logic [LANE_W-1:0]       lane_q;
  logic [8*WORD_BYTES-1:0] word_q;
  logic [ADDR_W-1:0]       addr_q;
  logic                    err_q;

  logic start_ok, too_long, accept, last_byte, wr_done, all_sent;

  assign start_ok  = i_start && ((state_q == IDLE) || (state_q == DONE));
  assign too_long  = 64'(i_len_bytes) > CAP_BYTES;
  assign accept    = (state_q == PACK) && i_byte_vld;
  assign last_byte = (cnt_q + LEN_W'(1)) == len_q;
  assign wr_done   = (state_q == WRITE) && i_instr_mem_wr_rdy;
  assign all_sent  = cnt_q == len_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d               = state_q;
    o_byte_rdy            = 1'b0;
    o_instr_mem_wr_vld    = 1'b0;
    o_instr_mem_wr_finish = 1'b0;
    o_busy                = 1'b0;
    o_err                 = err_q;
    o_instr_mem_wr_addr   = addr_q;
    o_instr_mem_wr_data   = word_q;
    case (state_q)
      IDLE, DONE: begin
        o_instr_mem_wr_finish = (state_q == DONE);
        if (i_start) begin
          if (too_long)                  state_d = IDLE;
          else if (i_len_bytes == '0)    state_d = DONE;
          else                           state_d = PACK;
        end
      end
      PACK: begin
        o_byte_rdy = 1'b1;
        o_busy     = 1'b1;
        if (accept && ((lane_q == LAST_LANE) || last_byte)) state_d = WRITE;
      end
      WRITE: begin
        o_instr_mem_wr_vld = 1'b1;
        o_busy             = 1'b1;
        if (i_instr_mem_wr_rdy) state_d = all_sent ? DONE : PACK;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      len_q  <= '0;
      cnt_q  <= '0;
      lane_q <= '0;
      word_q <= '0;
      addr_q <= '0;
      err_q  <= 1'b0;
    end else if (start_ok) begin
      len_q  <= i_len_bytes;
      cnt_q  <= '0;
      lane_q <= '0;
      word_q <= '0;
      addr_q <= '0;
      err_q  <= too_long;
    end else if (accept) begin
      for (int unsigned k = 0; k < WORD_BYTES; k++) begin
        if (lane_q == LANE_W'(k)) word_q[8*k +: 8] <= i_byte;
      end
      cnt_q  <= cnt_q + LEN_W'(1);
      lane_q <= (lane_q == LAST_LANE) ? '0 : lane_q + LANE_W'(1);
    end else if (wr_done) begin
      // Clearing the word here leaves unfilled lanes of a final partial word at zero
      word_q <= '0;
      lane_q <= '0;
      addr_q <= addr_q + ADDR_W'(1);
    end
  end

`ifdef WASM_LOADER_CHECKSUM_EN
  logic [31:0] csum_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      csum_q <= '0;
    else if (start_ok) csum_q <= '0;
    else if (accept)   csum_q <= csum_q + 32'(i_byte);
  end

  assign o_checksum = csum_q;
`else
  assign o_checksum = '0;
`endif

endmodule

// File: tb/tb_wasm_instr_loader.sv
// Directed bench for wasm_instr_loader: default, ADDR_W=2 and WORD_BYTES=4 instances.
module tb_wasm_instr_loader;

  localparam bit CSUM_ON =
`ifdef WASM_LOADER_CHECKSUM_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] len;
  logic [7:0]  byte_d;
  logic        wr_rdy;
  logic [2:0]  start_v, vld_v;

  logic        d_rdy, d_vld, d_fin, d_busy, d_err;
  logic [14:0] d_addr;
  logic [63:0] d_data;
  logic [31:0] d_csum;

  logic        a_rdy, a_vld, a_fin, a_busy, a_err;
  logic [1:0]  a_addr;
  logic [63:0] a_data;
  logic [31:0] a_csum;

  logic        w_rdy, w_vld, w_fin, w_busy, w_err;
  logic [14:0] w_addr;
  logic [31:0] w_data;
  logic [31:0] w_csum;

  int checks = 0;
  int failures = 0;

  logic [14:0] q_addr[$];
  logic [63:0] q_data[$];
  logic [14:0] wq_addr[$];
  logic [31:0] wq_data[$];
  int          a_writes = 0;

  wasm_instr_loader dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_v[0]), .i_len_bytes(len),
    .i_byte_vld(vld_v[0]), .i_byte(byte_d), .o_byte_rdy(d_rdy),
    .o_instr_mem_wr_vld(d_vld), .o_instr_mem_wr_addr(d_addr), .o_instr_mem_wr_data(d_data),
    .i_instr_mem_wr_rdy(wr_rdy), .o_instr_mem_wr_finish(d_fin), .o_busy(d_busy),
    .o_err(d_err), .o_checksum(d_csum)
  );

  wasm_instr_loader #(.ADDR_W(2)) dut_a2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_v[1]), .i_len_bytes(len),
    .i_byte_vld(vld_v[1]), .i_byte(byte_d), .o_byte_rdy(a_rdy),
    .o_instr_mem_wr_vld(a_vld), .o_instr_mem_wr_addr(a_addr), .o_instr_mem_wr_data(a_data),
    .i_instr_mem_wr_rdy(wr_rdy), .o_instr_mem_wr_finish(a_fin), .o_busy(a_busy),
    .o_err(a_err), .o_checksum(a_csum)
  );

  wasm_instr_loader #(.WORD_BYTES(4)) dut_w4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_v[2]), .i_len_bytes(len),
    .i_byte_vld(vld_v[2]), .i_byte(byte_d), .o_byte_rdy(w_rdy),
    .o_instr_mem_wr_vld(w_vld), .o_instr_mem_wr_addr(w_addr), .o_instr_mem_wr_data(w_data),
    .i_instr_mem_wr_rdy(wr_rdy), .o_instr_mem_wr_finish(w_fin), .o_busy(w_busy),
    .o_err(w_err), .o_checksum(w_csum)
  );

  // Completed writes are logged at the falling edge preceding the completing rising edge
  always @(negedge clk) begin
    if (d_vld && wr_rdy) begin
      q_addr.push_back(d_addr);
      q_data.push_back(d_data);
    end
    if (w_vld && wr_rdy) begin
      wq_addr.push_back(w_addr);
      wq_data.push_back(w_data);
    end
    if (a_vld) a_writes++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy_of(input int sel);
    return (sel == 0) ? d_rdy : (sel == 1) ? a_rdy : w_rdy;
  endfunction

  function automatic logic fin_of(input int sel);
    return (sel == 0) ? d_fin : (sel == 1) ? a_fin : w_fin;
  endfunction

  task automatic pulse(input int sel, input logic [31:0] l);
    len = l;
    start_v[sel] = 1'b1;
    tick();
    start_v[sel] = 1'b0;
  endtask

  task automatic push(input int sel, input logic [7:0] b);
    bit done = 1'b0;
    int n = 0;
    byte_d = b;
    vld_v[sel] = 1'b1;
    while (!done && n < 50) begin
      @(negedge clk);
      done = rdy_of(sel);
      tick();
      n++;
    end
    vld_v[sel] = 1'b0;
    if (!done) chk("push_timeout", 64'(done), 64'(1));
  endtask

  task automatic wait_fin(input int sel);
    int n = 0;
    while (!fin_of(sel) && n < 200) begin
      tick();
      n++;
    end
    chk("finish_wait", 64'(fin_of(sel)), 64'(1));
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_rdy"},  64'(d_rdy),  64'(0));
    chk({tag, "_vld"},  64'(d_vld),  64'(0));
    chk({tag, "_addr"}, 64'(d_addr), 64'(0));
    chk({tag, "_data"}, d_data,      64'(0));
    chk({tag, "_fin"},  64'(d_fin),  64'(0));
    chk({tag, "_busy"}, 64'(d_busy), 64'(0));
    chk({tag, "_err"},  64'(d_err),  64'(0));
    chk({tag, "_csum"}, 64'(d_csum), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0; len = '0; byte_d = '0; wr_rdy = 1'b1; start_v = '0; vld_v = '0;
    repeat (3) tick();
    @(negedge clk);
    chk_idle_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Zero-length program finishes immediately without writing
    pulse(0, 0);
    @(negedge clk);
    chk("len0_fin",  64'(d_fin),  64'(1));
    chk("len0_busy", 64'(d_busy), 64'(0));
    chk("len0_nwr",  64'(q_addr.size()), 64'(0));
    tick();

    // Two full words
    pulse(0, 16);
    @(negedge clk);
    chk("l16_fin_drop", 64'(d_fin),  64'(0));
    chk("l16_busy",     64'(d_busy), 64'(1));
    tick();
    for (int i = 0; i < 16; i++) push(0, 8'(i));
    wait_fin(0);
    chk("l16_nwr",   64'(q_addr.size()), 64'(2));
    chk("l16_a0",    64'(q_addr[0]), 64'(0));
    chk("l16_d0",    q_data[0], 64'h0706050403020100);
    chk("l16_a1",    64'(q_addr[1]), 64'(1));
    chk("l16_d1",    q_data[1], 64'h0F0E0D0C0B0A0908);
    chk("l16_csum",  64'(d_csum), CSUM_ON ? 64'd120 : 64'd0);
    chk("l16_busy0", 64'(d_busy), 64'(0));

    // Partial final word, with a start pulse mid-load that must be ignored
    q_addr.delete(); q_data.delete();
    pulse(0, 10);
    for (int i = 1; i <= 3; i++) push(0, 8'(i));
    pulse(0, 0);
    @(negedge clk);
    chk("ign_busy", 64'(d_busy), 64'(1));
    chk("ign_fin",  64'(d_fin),  64'(0));
    tick();
    for (int i = 4; i <= 10; i++) push(0, 8'(i));
    wait_fin(0);
    chk("l10_nwr",  64'(q_addr.size()), 64'(2));
    chk("l10_d0",   q_data[0], 64'h0807060504030201);
    chk("l10_a1",   64'(q_addr[1]), 64'(1));
    chk("l10_d1",   q_data[1], 64'h0000000000000A09);
    chk("l10_csum", 64'(d_csum), CSUM_ON ? 64'd55 : 64'd0);

    // Memory back-pressure holds the write stable and blocks further bytes
    q_addr.delete(); q_data.delete();
    wr_rdy = 1'b0;
    pulse(0, 8);
    for (int i = 0; i < 8; i++) push(0, 8'(8'hA0 + i));
    byte_d = 8'hEE;
    vld_v[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_vld",  64'(d_vld),  64'(1));
      chk("stall_addr", 64'(d_addr), 64'(0));
      chk("stall_data", d_data, 64'hA7A6A5A4A3A2A1A0);
      chk("stall_brdy", 64'(d_rdy),  64'(0));
    end
    tick();
    wr_rdy = 1'b1;
    wait_fin(0);
    vld_v[0] = 1'b0;
    chk("stall_nwr",  64'(q_addr.size()), 64'(1));
    chk("stall_d0",   q_data[0], 64'hA7A6A5A4A3A2A1A0);
    chk("stall_csum", 64'(d_csum), CSUM_ON ? 64'd1308 : 64'd0);

    // Reset in the middle of a word, then a clean reload
    pulse(0, 16);
    push(0, 8'h55); push(0, 8'h66); push(0, 8'h77);
    rst_n = 1'b0;
    @(negedge clk);
    chk_idle_zero("midrst");
    tick();
    rst_n = 1'b1;
    q_addr.delete(); q_data.delete();
    tick();
    pulse(0, 8);
    for (int i = 0; i < 8; i++) push(0, 8'(8'h21 + i));
    wait_fin(0);
    chk("rl_nwr",  64'(q_addr.size()), 64'(1));
    chk("rl_a0",   64'(q_addr[0]), 64'(0));
    chk("rl_d0",   q_data[0], 64'h2827262524232221);
    chk("rl_csum", 64'(d_csum), CSUM_ON ? 64'd292 : 64'd0);

    // Capacity boundary on a 4-word memory
    pulse(1, 33);
    @(negedge clk);
    chk("a2_err",  64'(a_err),  64'(1));
    chk("a2_busy", 64'(a_busy), 64'(0));
    chk("a2_fin",  64'(a_fin),  64'(0));
    chk("a2_brdy", 64'(a_rdy),  64'(0));
    repeat (3) tick();
    chk("a2_nwr",  64'(a_writes), 64'(0));
    pulse(1, 32);
    @(negedge clk);
    chk("a2_fit_err",  64'(a_err),  64'(0));
    chk("a2_fit_busy", 64'(a_busy), 64'(1));
    tick();

    // Narrow 4-byte words
    pulse(2, 8);
    for (int i = 0; i < 8; i++) push(2, 8'(8'h11 + i));
    wait_fin(2);
    chk("w4_nwr", 64'(wq_addr.size()), 64'(2));
    chk("w4_a0",  64'(wq_addr[0]), 64'(0));
    chk("w4_d0",  64'(wq_data[0]), 64'h14131211);
    chk("w4_a1",  64'(wq_addr[1]), 64'(1));
    chk("w4_d1",  64'(wq_data[1]), 64'h18171615);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
